gol_pixel_pipe: RTL and testbench
=================================

GOL_PIXEL_PIPE -- requirements
Module: gol_pixel_pipe

Interface
REQ-001 SHALL have parameter PIX_BITS, default 4, meaning palette index width.
REQ-002 SHALL have parameter CH_BITS, default 8, meaning per-channel colour width.
REQ-003 SHALL have parameter X_BITS, default 10, meaning video_x width.
REQ-004 SHALL have parameter Y_BITS, default 10, meaning video_y width.
REQ-005 SHALL have parameter GRID_SHIFT, default 3, meaning grid pitch of 2^GRID_SHIFT pixels.
REQ-006 SHALL have port clk_25, input, 1, the single pixel clock.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port video_x, input, X_BITS, current pixel column.
REQ-009 SHALL have port video_y, input, Y_BITS, current pixel row.
REQ-010 SHALL have port display_enable, input, 1, active-area flag.
REQ-011 SHALL have port frame_end, input, 1, one-cycle end-of-frame strobe.
REQ-012 SHALL have port pixel_in, input, PIX_BITS, memory pixel aligned with video_x/video_y.
REQ-013 SHALL have port mode_sel, input, 2, requested display mode.
REQ-014 SHALL have port swap_req, input, 1, level request to flip the display bank.
REQ-015 SHALL have port swap_ack, output, 1, one-cycle pulse confirming a bank flip.
REQ-016 SHALL have port bank, output, 1, memory bank currently displayed.
REQ-017 SHALL have ports r, g and b, each output, CH_BITS, colour channels.
REQ-018 SHALL have port de_out, output, 1, display_enable delayed to align with r/g/b.

Function
REQ-019 SHALL hold an active mode register mode_q, loaded from mode_sel only on edges where frame_end=1.
REQ-020 SHALL encode modes as 0 COUNTER, 1 MEMORY, 2 BARS and 3 GRID.
REQ-021 SHALL keep a PIX_BITS free-running counter that increments on every edge with display_enable=1 and wraps at 2^PIX_BITS-1 to 0.
REQ-022 SHALL keep an 8-bit frame_cnt that increments on every frame_end and wraps at 255 to 0.
REQ-023 SHALL form the index as: COUNTER = counter; MEMORY = pixel_in; BARS = (video_x[X_BITS-1 -: PIX_BITS] + frame_cnt[PIX_BITS-1:0]) mod 2^PIX_BITS.
REQ-024 SHALL form the GRID index as all-ones when video_x[GRID_SHIFT-1:0]==0 or video_y[GRID_SHIFT-1:0]==0, and pixel_in otherwise.
REQ-025 Stage 1 SHALL register the index and display_enable.
REQ-026 Stage 2 SHALL map the index through the palette, register r/g/b, and force r/g/b to 0 when the stage-1 enable is 0.
REQ-027 SHALL give r/g/b/de_out a fixed latency of exactly 2 cycles from video_x/video_y/pixel_in/display_enable.
REQ-028 On an edge with frame_end=1 and swap_req=1, SHALL toggle bank and assert swap_ack for exactly the following cycle.
REQ-029 On an edge with frame_end=1 and swap_req=0, SHALL leave bank unchanged and hold swap_ack at 0.
REQ-030 SHALL generate at most one swap_ack per frame_end, even when swap_req is held high across several frames.
REQ-031 When frame_end and display_enable are both 1 on the same edge, SHALL index that pixel with the old mode_q and old frame_cnt.
REQ-032 The palette SHALL be a fixed map in which index 0 is black and index all-ones is white, all channels full-scale.

Reset
REQ-033 While rst_n=0, SHALL hold mode_q, counter, frame_cnt, bank, swap_ack, both pipeline stages, r, g, b and de_out at 0.
REQ-034 A reset asserted mid-frame SHALL clear the pipeline immediately, and no stale pixel SHALL appear after release.

Structure
REQ-035 Package gol_video_pkg SHALL hold the mode enum type and the default parameter constants.
REQ-036 The palette SHALL be a separate combinational sub-module gol_palette, parametrised by PIX_BITS and CH_BITS.

Verification
REQ-037 Reset release with mode_sel=0 and display_enable=1 for 20 cycles -> de_out rises 2 cycles later; the index sequence is 0,1,...,15,0,1,2,3.
REQ-038 mode_sel=1 with pixel_in=0xF and display_enable=1 -> r=g=b=0xFF 2 cycles later; display_enable=0 gives r=g=b=0 2 cycles later.
REQ-039 mode_sel changed mid-frame -> output unchanged until the pixel after the next frame_end uses the new mode.
REQ-040 swap_req held high over 3 frame_end strobes -> bank toggles 3 times; swap_ack shows 3 single-cycle pulses, each one cycle after a strobe.
REQ-041 mode 3 with pixel_in=0x2 at (x=8,y=5) and (x=9,y=5) -> index 0xF, then 0x2.
REQ-042 rst_n pulled low mid-line -> all outputs 0 asynchronously, and bank returns to 0.

Source files
------------

// File: rtl/gol_video_pkg.sv
// Shared types and default sizing for the video pixel pipeline.
package gol_video_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_MEMORY  = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_GRID    = 2'd3
  } mode_e;

  localparam int unsigned DEF_PIX_BITS   = 4;
  localparam int unsigned DEF_CH_BITS    = 8;
  localparam int unsigned DEF_X_BITS     = 10;
  localparam int unsigned DEF_Y_BITS     = 10;
  localparam int unsigned DEF_GRID_SHIFT = 3;
  localparam int unsigned FRAME_CNT_BITS = 8;

endpackage

// File: rtl/gol_palette.sv
// Fixed combinational palette: red is the index, green its bit-reverse, blue its left rotation,
// each stretched to full channel width by bit replication (0 -> black, all-ones -> white).
module gol_palette
  import gol_video_pkg::*;
#(
  parameter int unsigned PIX_BITS = DEF_PIX_BITS,
  parameter int unsigned CH_BITS  = DEF_CH_BITS
) (
  input  logic [PIX_BITS-1:0] i_idx,
  output logic [CH_BITS-1:0]  o_r_c,
  output logic [CH_BITS-1:0]  o_g_c,
  output logic [CH_BITS-1:0]  o_b_c
);

  logic [PIX_BITS-1:0] w_rev;
  logic [PIX_BITS-1:0] w_rot;

  for (genvar j = 0; j < PIX_BITS; j++) begin : g_perm
    assign w_rev[j] = i_idx[PIX_BITS-1-j];
    assign w_rot[j] = i_idx[(j+PIX_BITS-1) % PIX_BITS];
  end

  // Repeat the index MSB-first across the channel so the full range maps to 0..max.
  for (genvar c = 0; c < CH_BITS; c++) begin : g_scale
    assign o_r_c[c] = i_idx[PIX_BITS-1-((CH_BITS-1-c) % PIX_BITS)];
    assign o_g_c[c] = w_rev[PIX_BITS-1-((CH_BITS-1-c) % PIX_BITS)];
    assign o_b_c[c] = w_rot[PIX_BITS-1-((CH_BITS-1-c) % PIX_BITS)];
  end

endmodule

// File: rtl/gol_pixel_pipe.sv
// Two-stage pixel pipeline: per-mode palette index selection, palette lookup, and
// frame-synchronous mode latch and display-bank flip.
module gol_pixel_pipe
  import gol_video_pkg::*;
#(
  parameter int unsigned PIX_BITS   = DEF_PIX_BITS,
  parameter int unsigned CH_BITS    = DEF_CH_BITS,
  parameter int unsigned X_BITS     = DEF_X_BITS,
  parameter int unsigned Y_BITS     = DEF_Y_BITS,
  parameter int unsigned GRID_SHIFT = DEF_GRID_SHIFT
) (
  input  logic                clk_25,
  input  logic                rst_n,
  input  logic [X_BITS-1:0]   video_x,
  input  logic [Y_BITS-1:0]   video_y,
  input  logic                display_enable,
  input  logic                frame_end,
  input  logic [PIX_BITS-1:0] pixel_in,
  input  logic [1:0]          mode_sel,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                bank,
  output logic [CH_BITS-1:0]  r,
  output logic [CH_BITS-1:0]  g,
  output logic [CH_BITS-1:0]  b,
  output logic                de_out
);

  mode_e                     r_mode_q;
  logic [PIX_BITS-1:0]       r_counter;
  logic [FRAME_CNT_BITS-1:0] r_frame_cnt;
  logic                      r_bank;
  logic                      r_swap_ack;
  logic [PIX_BITS-1:0]       r_s1_idx;
  logic                      r_s1_de;
  logic [CH_BITS-1:0]        r_r;
  logic [CH_BITS-1:0]        r_g;
  logic [CH_BITS-1:0]        r_b;
  logic                      r_de;

  logic [PIX_BITS-1:0]       w_idx;
  logic                      w_grid_line;
  logic [CH_BITS-1:0]        w_pal_r;
  logic [CH_BITS-1:0]        w_pal_g;
  logic [CH_BITS-1:0]        w_pal_b;
  logic                      w_unused_bits;

  // Only the top and bottom coordinate bits feed the index.
  assign w_unused_bits = ^{video_x, video_y};

  assign w_grid_line = (video_x[GRID_SHIFT-1:0] == '0) || (video_y[GRID_SHIFT-1:0] == '0);

  // Index selection uses the mode/frame count in effect before any same-edge frame_end.
  always_comb begin
    w_idx = r_counter;
    case (r_mode_q)
      MODE_COUNTER: w_idx = r_counter;
      MODE_MEMORY:  w_idx = pixel_in;
      MODE_BARS:    w_idx = video_x[X_BITS-1 -: PIX_BITS] + PIX_BITS'(r_frame_cnt);
      MODE_GRID:    w_idx = w_grid_line ? '1 : pixel_in;
    endcase
  end

  gol_palette #(
    .PIX_BITS (PIX_BITS),
    .CH_BITS  (CH_BITS)
  ) u_palette (
    .i_idx (r_s1_idx),
    .o_r_c (w_pal_r),
    .o_g_c (w_pal_g),
    .o_b_c (w_pal_b)
  );

  // Frame-rate control state: mode latch, frame counter, bank flip handshake.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q    <= MODE_COUNTER;
      r_frame_cnt <= '0;
      r_bank      <= 1'b0;
      r_swap_ack  <= 1'b0;
    end else begin
      r_swap_ack <= frame_end & swap_req;
      if (frame_end) begin
        r_mode_q    <= mode_e'(mode_sel);
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_BITS'(1);
        if (swap_req) begin
          r_bank <= ~r_bank;
        end
      end
    end
  end

  // Pixel-rate pipeline.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_counter <= '0;
      r_s1_idx  <= '0;
      r_s1_de   <= 1'b0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_de      <= 1'b0;
    end else begin
      if (display_enable) begin
        r_counter <= r_counter + PIX_BITS'(1);
      end
      r_s1_idx <= w_idx;
      r_s1_de  <= display_enable;
      r_r      <= r_s1_de ? w_pal_r : '0;
      r_g      <= r_s1_de ? w_pal_g : '0;
      r_b      <= r_s1_de ? w_pal_b : '0;
      r_de     <= r_s1_de;
    end
  end

  assign swap_ack = r_swap_ack;
  assign bank     = r_bank;
  assign r        = r_r;
  assign g        = r_g;
  assign b        = r_b;
  assign de_out   = r_de;

endmodule

// File: tb/tb_gol_pixel_pipe.sv
// Directed plus random bench for gol_pixel_pipe against a plain arithmetic reference model.
module tb_gol_pixel_pipe;

  localparam int unsigned PIX = 4;
  localparam int unsigned CH  = 8;
  localparam int unsigned XB  = 10;
  localparam int unsigned YB  = 10;
  localparam int unsigned GS  = 3;
  localparam int          PMAX = (1 << PIX) - 1;
  localparam int          CMAX = (1 << CH) - 1;

  logic          clk_25 = 1'b0;
  logic          rst_n  = 1'b1;
  logic [XB-1:0] video_x = '0;
  logic [YB-1:0] video_y = '0;
  logic          display_enable = 1'b0;
  logic          frame_end = 1'b0;
  logic [PIX-1:0] pixel_in = '0;
  logic [1:0]    mode_sel = 2'd0;
  logic          swap_req = 1'b0;
  logic          swap_ack;
  logic          bank;
  logic [CH-1:0] r;
  logic [CH-1:0] g;
  logic [CH-1:0] b;
  logic          de_out;

  gol_pixel_pipe #(
    .PIX_BITS(PIX), .CH_BITS(CH), .X_BITS(XB), .Y_BITS(YB), .GRID_SHIFT(GS)
  ) dut (
    .clk_25(clk_25), .rst_n(rst_n), .video_x(video_x), .video_y(video_y),
    .display_enable(display_enable), .frame_end(frame_end), .pixel_in(pixel_in),
    .mode_sel(mode_sel), .swap_req(swap_req), .swap_ack(swap_ack), .bank(bank),
    .r(r), .g(g), .b(b), .de_out(de_out)
  );

  always #20 clk_25 = ~clk_25;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int m_mode, m_cnt, m_fc, m_bank;
  logic [24:0] exp_q[$];

  function automatic int scale(input int v);
    return (v * CMAX) / PMAX;
  endfunction

  // Reference palette: red = index, green = bit-reversed index, blue = index rotated left by one.
  function automatic logic [23:0] pal(input int v);
    int rv = 0;
    int rot;
    for (int k = 0; k < PIX; k++) begin
      if (((v >> k) & 1) != 0) rv += 1 << (PIX - 1 - k);
    end
    rot = ((v << 1) | (v >> (PIX - 1))) & PMAX;
    return {8'(scale(v)), 8'(scale(rv)), 8'(scale(rot))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int x, input int y, input int pin, input int de,
                      input int fe, input int msel, input int sreq);
    int idx;
    logic [24:0] e;
    video_x        = XB'(x);
    video_y        = YB'(y);
    pixel_in       = PIX'(pin);
    display_enable = (de != 0);
    frame_end      = (fe != 0);
    mode_sel       = 2'(msel);
    swap_req       = (sreq != 0);
    case (m_mode)
      0:       idx = m_cnt;
      1:       idx = pin;
      2:       idx = ((x >> (XB - PIX)) + m_fc) % (PMAX + 1);
      default: idx = ((x % (1 << GS)) == 0 || (y % (1 << GS)) == 0) ? PMAX : pin;
    endcase
    e = (de != 0) ? {1'b1, pal(idx)} : 25'd0;
    exp_q.push_back(e);
    if (de != 0) m_cnt = (m_cnt + 1) % (PMAX + 1);
    if (fe != 0) begin
      m_fc   = (m_fc + 1) % 256;
      m_mode = msel;
      if (sreq != 0) m_bank ^= 1;
    end
    @(posedge clk_25);
    #1;
    chk("bank", 32'(bank), 32'(m_bank));
    chk("swap_ack", 32'(swap_ack), 32'((fe != 0) && (sreq != 0)));
    if (swap_ack) ack_cnt++;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk("de_out", 32'(de_out), 32'(e[24]));
      chk("rgb", 32'({r, g, b}), 32'(e[23:0]));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_de_out", 32'(de_out), 32'd0);
    chk("rst_bank", 32'(bank), 32'd0);
    chk("rst_swap_ack", 32'(swap_ack), 32'd0);
    @(posedge clk_25);
    #1;
    rst_n  = 1'b1;
    m_mode = 0;
    m_cnt  = 0;
    m_fc   = 0;
    m_bank = 0;
    exp_q.delete();
    exp_q.push_back(25'd0);
  endtask

  initial begin
    int bank0;
    #1;
    do_reset();

    // Counter mode straight out of reset.
    for (int i = 0; i < 20; i++) step(i, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Memory mode: white for full-scale pixel, black when blanked.
    step(0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(i, 1, 15, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(i, 1, 15, 0, 0, 1, 0);

    // Mode change mid-frame only takes effect after frame_end; frame_end pixel uses old mode.
    for (int i = 0; i < 4; i++) step(64 * i + 5, 2, 3, 1, 0, 2, 0);
    step(900, 2, 7, 1, 1, 2, 0);
    for (int i = 0; i < 4; i++) step(64 * i + 5, 3, 3, 1, 0, 2, 0);

    // Held swap request across three frame ends.
    ack_cnt = 0;
    bank0   = m_bank;
    for (int f = 0; f < 3; f++) begin
      step(1, 1, 1, 1, 1, 2, 1);
      for (int i = 0; i < 3; i++) step(i, 1, 1, 1, 0, 2, 1);
    end
    step(0, 0, 0, 0, 0, 2, 0);
    chk("ack_pulses", 32'(ack_cnt), 32'd3);
    chk("bank_flips", 32'(bank), 32'(bank0 ^ 1));

    // Grid mode on and off a grid line.
    step(0, 0, 0, 0, 1, 3, 0);
    step(8, 5, 2, 1, 0, 3, 0);
    step(9, 5, 2, 1, 0, 3, 0);
    step(9, 8, 2, 1, 0, 3, 0);
    step(0, 0, 0, 0, 0, 3, 0);
    step(0, 0, 0, 0, 0, 3, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, (1 << XB) - 1), $urandom_range(0, (1 << YB) - 1),
           $urandom_range(0, PMAX), int'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 15) == 0), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    // Mid-line reset with a live pipeline, then no stale pixels afterwards.
    for (int i = 0; i < 4; i++) step(i, 0, 15, 1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) step(i, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
